// File: rtl/digit_scanner.sv
// Four-digit multiplexed BCD display scanner feeding a seven-segment decoder.
// Values are double-buffered and swapped only at the frame wrap, so digits never tear.
module digit_scanner #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_en,
    output logic        frame_done
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(DIV - 1);

    // Digit k of v as a decoder code; 4'hF blanks invalid nibbles and, when
    // enabled, zeros with no non-zero digit above them (digit 0 always shows).
    function automatic logic [3:0] digit_code(input logic [15:0] v,
                                              input logic [1:0]  k,
                                              input logic        blz);
        logic [3:0] nib;
        logic       lz;
        nib = 4'h0;
        lz  = 1'b0;
        case (k)
            2'd0: begin nib = v[3:0];   lz = 1'b0;                 end
            2'd1: begin nib = v[7:4];   lz = (v[15:4]  == 12'h000); end
            2'd2: begin nib = v[11:8];  lz = (v[15:8]  == 8'h00);   end
            2'd3: begin nib = v[15:12]; lz = (v[15:12] == 4'h0);    end
            default: begin nib = 4'hF;  lz = 1'b0;                 end
        endcase
        if (nib > 4'd9) begin
            return 4'hF;
        end else if (blz && lz) begin
            return 4'hF;
        end else begin
            return nib;
        end
    endfunction

    logic [CW-1:0] tick_cnt_r;
    logic [1:0]    idx_r;
    logic [15:0]   shadow_r;
    logic [15:0]   active_r;
    logic          pending_r;

    logic          tick_s;
    logic          wrap_s;
    logic [CW-1:0] tick_cnt_next_s;
    logic [1:0]    idx_next_s;
    logic [15:0]   shadow_next_s;
    logic [15:0]   active_next_s;
    logic          pending_next_s;

    // Next-state logic for prescaler, scan index and the double buffer.
    always_comb begin
        tick_s          = (tick_cnt_r == TICK_MAX);
        wrap_s          = tick_s && (idx_r == 2'd3);
        tick_cnt_next_s = tick_cnt_r;
        idx_next_s      = idx_r;
        shadow_next_s   = shadow_r;
        active_next_s   = active_r;
        pending_next_s  = pending_r;

        if (tick_s) begin
            tick_cnt_next_s = {CW{1'b0}};
            idx_next_s      = idx_r + 2'd1;
        end else begin
            tick_cnt_next_s = tick_cnt_r + CW'(1);
            idx_next_s      = idx_r;
        end

        // The swap reads shadow before this edge; a coinciding load re-arms pending.
        if (wrap_s && pending_r) begin
            active_next_s = shadow_r;
        end else begin
            active_next_s = active_r;
        end

        if (load) begin
            shadow_next_s  = value_in;
            pending_next_s = 1'b1;
        end else if (wrap_s) begin
            shadow_next_s  = shadow_r;
            pending_next_s = 1'b0;
        end else begin
            shadow_next_s  = shadow_r;
            pending_next_s = pending_r;
        end
    end

    // State and output registers; outputs only move on a prescaler tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {CW{1'b0}};
            idx_r      <= 2'd0;
            shadow_r   <= 16'h0000;
            active_r   <= 16'h0000;
            pending_r  <= 1'b0;
            digit_en   <= 4'b0001;
            bcd_out    <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_next_s;
            idx_r      <= idx_next_s;
            shadow_r   <= shadow_next_s;
            active_r   <= active_next_s;
            pending_r  <= pending_next_s;
            frame_done <= wrap_s;
            if (tick_s) begin
                digit_en <= 4'b0001 << idx_next_s;
                bcd_out  <= digit_code(active_next_s, idx_next_s, blank_lz);
            end else begin
                digit_en <= digit_en;
                bcd_out  <= bcd_out;
            end
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner: expected slot contents are queued by the
// stimulus and popped by a monitor whenever the digit enable advances.
module tb_digit_scanner;

    localparam int DIV = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  exp_e;
    logic [3:0]  prev_en  = 4'b0001;
    logic [3:0]  prev_bcd = 4'h0;
    int          run      = 0;
    bit          skip_len = 1'b1;

    always #5 clk = ~clk;

    digit_scanner #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .bcd_out    (bcd_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_slot(input logic [3:0] en, input logic [3:0] d);
        sb_q.push_back({en, d});
    endtask

    task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        push_slot(4'b0001, d0);
        push_slot(4'b0010, d1);
        push_slot(4'b0100, d2);
        push_slot(4'b1000, d3);
    endtask

    task automatic wait_wrap();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #1;
            if (frame_done) seen = 1'b1;
        end
        check_eq("wrap_timeout", seen, 1);
    endtask

    task automatic wait_en(input logic [3:0] en);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #1;
            if (digit_en == en) seen = 1'b1;
        end
        check_eq("slot_timeout", seen, 1);
    endtask

    task automatic goto_slot(input logic [3:0] en);
        wait_wrap();
        if (en != 4'b0001) wait_en(en);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        @(negedge clk); #1;
        load     = 1'b0;
    endtask

    // Monitor: pops one expectation per slot change and checks slot invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en  = 4'b0001;
                prev_bcd = 4'h0;
                run      = 0;
                skip_len = 1'b1;
            end else begin
                check_eq("onehot", $onehot(digit_en), 1);
                if (digit_en != prev_en) begin
                    check_eq("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        exp_e = sb_q.pop_front();
                        check_eq("digit_en", digit_en, exp_e[7:4]);
                        check_eq("bcd_out", bcd_out, exp_e[3:0]);
                    end
                    check_eq("frame_done_wrap", frame_done, digit_en == 4'b0001);
                    if (!skip_len) check_eq("slot_len", run, DIV);
                    skip_len = 1'b0;
                    run      = 1;
                    prev_en  = digit_en;
                    prev_bcd = bcd_out;
                end else begin
                    check_eq("frame_done_idle", frame_done, 0);
                    check_eq("bcd_hold", bcd_out, prev_bcd);
                    run++;
                end
            end
        end
    end

    // Stimulus: loads and blanking changes aligned to known slots.
    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_digit_en", digit_en, 4'b0001);
        check_eq("rst_bcd_out", bcd_out, 4'h0);
        check_eq("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;

        push_slot(4'b0010, 4'h0);
        push_slot(4'b0100, 4'h0);
        push_slot(4'b1000, 4'h0);
        push_frame(4'h0, 4'h0, 4'h0, 4'h0);
        push_frame(4'h4, 4'h3, 4'h2, 4'h1);

        goto_slot(4'b0010);
        pulse_load(16'h1234);

        goto_slot(4'b1000);
        blank_lz = 1'b1;
        push_frame(4'h0, 4'h5, 4'hF, 4'hF);
        pulse_load(16'h0050);

        goto_slot(4'b1000);
        push_frame(4'h0, 4'hF, 4'hF, 4'hF);
        pulse_load(16'h0000);

        goto_slot(4'b1000);
        push_frame(4'h0, 4'h0, 4'h0, 4'h1);
        pulse_load(16'h1000);

        goto_slot(4'b1000);
        blank_lz = 1'b0;
        push_frame(4'h3, 4'hF, 4'h9, 4'hF);
        pulse_load(16'hA9C3);

        // Second load lands on the wrap-tick edge (tick_cnt == DIV-1 in slot 3).
        goto_slot(4'b0010);
        push_frame(4'h1, 4'h1, 4'h1, 4'h1);
        push_frame(4'h2, 4'h2, 4'h2, 4'h2);
        pulse_load(16'h1111);
        wait_en(4'b1000);
        repeat (DIV - 1) @(negedge clk);
        #1;
        pulse_load(16'h2222);

        goto_slot(4'b0010);
        push_slot(4'b0001, 4'h6);
        push_slot(4'b0010, 4'h6);
        push_slot(4'b0100, 4'h6);
        pulse_load(16'h5555);
        wait_en(4'b0100);
        pulse_load(16'h6666);

        goto_slot(4'b0010);
        pulse_load(16'h7777);
        wait_en(4'b0100);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_digit_en", digit_en, 4'b0001);
        check_eq("midrst_bcd_out", bcd_out, 4'h0);
        check_eq("midrst_frame_done", frame_done, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        push_slot(4'b0010, 4'h0);
        push_slot(4'b0100, 4'h0);
        push_slot(4'b1000, 4'h0);
        push_frame(4'h0, 4'h0, 4'h0, 4'h0);
        push_slot(4'b0001, 4'h0);
        wait_wrap();
        wait_wrap();
        repeat (2) @(negedge clk);
        #1;
        check_eq("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1);
    end

endmodule

// File: doc/digit_scanner.md
# digit_scanner

Four-digit time-multiplexed display scanner that sits directly upstream of the BCD-to-seven-segment decoder. It holds a 16-bit packed BCD value and walks one digit at a time onto a shared 4-bit `bcd_out` bus, together with a one-hot digit enable. It blanks leading zeros and invalid nibbles by driving code 4'hF, which the decoder renders as all segments off. New values take effect only at frame boundaries, so a displayed number never tears.

## Interface
- `DIV`, default 50000: clock cycles per digit slot. Must be ≥ 1; `DIV` = 1 advances every cycle.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value_in`  in  16  packed BCD value; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- `load`  in  1  single-cycle strobe; captures `value_in` into the shadow register.
- `blank_lz`  in  1  leading-zero blanking enable; sampled every cycle.
- `bcd_out`  out  4  nibble for the current digit; 4'hF means blank.
- `digit_en`  out  4  one-hot, active-high select of the digit being driven.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Registers:
  - prescaler `tick_cnt`, width $clog2(DIV), min 1.
  - digit index `idx`, 2 bits.
  - `shadow`, 16 bits.
  - `active`, 16 bits.
  - `pending` flag.
  - all outputs are flops.
- Prescaler: counts 0..DIV-1. `tick` is true when `tick_cnt` == DIV-1. On `tick` the counter returns to 0; otherwise it increments.
- Scan: on `tick`, `idx` advances 0→1→2→3→0. `digit_en` equals 1<<idx_next, registered on the same edge.
- Load: when `load` = 1, `shadow` <= `value_in` and `pending` <= 1. Back-to-back loads overwrite: the last one wins.
- Frame swap: on a `tick` where `idx` == 3:
  - if `pending`, then `active` <= `shadow` and `pending` is cleared;
  - `frame_done` pulses for that cycle.
- Load coinciding with a swap:
  - the swap uses the `shadow` contents from before the edge;
  - the new value is written to `shadow`;
  - `pending` ends at 1, so the new value shows in the next frame.
- Digit value: `bcd_out` is registered. It is computed from idx_next and active_next, so the first digit of a new frame already shows the new value.
- Invalid nibble: any nibble > 9 is output as 4'hF.
- Leading-zero blanking: when `blank_lz` = 1, digit k (k = 3, 2, 1) outputs 4'hF if nibble k and every higher nibble equal 0. Digit 0 is never blanked by this rule. A value of 0 therefore displays as a single "0".
- Blanking is evaluated on `active`, never on `shadow`.

## Timing
- Reset (async assert, release synchronous to `clk`):
  - `tick_cnt` = 0, `idx` = 0;
  - `shadow` = 0, `active` = 0, `pending` = 0;
  - `digit_en` = 4'b0001, `bcd_out` = 4'h0, `frame_done` = 0.
- Reset mid-frame or mid-load: all state returns to the reset values immediately, and any pending load is discarded.
- Each digit is held for exactly `DIV` cycles. A frame lasts 4·`DIV` cycles.
- After reset release, the first `tick` occurs DIV-1 cycles later. `digit_en` becomes 4'b0010 on that edge.
- `digit_en`, `bcd_out` and `frame_done` change on the same clock edge. There are never zero-hot or two-hot enable cycles.
- Load-to-display latency: displayed at the next 3→0 wrap after capture, which is between 1 and 4·`DIV` cycles.
- `blank_lz` changes take effect on the next `tick` edge.

## Test plan
- Reset, then DIV=4 and no load:
  - `digit_en` cycles 0001, 0010, 0100, 1000, each for 4 clocks;
  - `bcd_out` = 0 on every digit with `blank_lz` = 0;
  - `frame_done` pulses once every 16 clocks, on the edge returning to 0001.
- Load 16'h1234 mid-frame (at idx = 1):
  - the current frame still shows 0,0,0,0;
  - the next frame shows 4, 3, 2, 1 for digits 0..3.
- `blank_lz` = 1:
  - value 16'h0050 gives 0, 5, F, F;
  - value 16'h0000 gives 0, F, F, F;
  - value 16'h1000 gives 0, 0, 0, 1.
- Invalid nibble: value 16'hA9C3 gives 3, F, 9, F.
- Load collision:
  - load 16'h1111, then load 16'h2222 on the wrap-tick cycle;
  - the next frame shows 1111 and the frame after shows 2222;
  - two loads in one frame show only the last value.
- Assert `rst_n` low for one cycle mid-frame with `pending` set:
  - outputs return to 0001 / 0 / 0 immediately;
  - after release the pending value is never displayed.
